// File: rtl/rv32i_types.sv
// Shared RV32I datapath types and load/store funct3 encodings for the data-memory path.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  // Byte enables for an aligned access; funct3[1:0] carries the size for loads and stores alike.
  function automatic rv32i_mem_wmask gen_wmask(input logic [2:0] funct3, input logic [1:0] offset);
    rv32i_mem_wmask mask;
    case (funct3[1:0])
      2'b00:   mask = 4'b0001 << offset;
      2'b01:   mask = offset[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Data-memory request/response bus between the controller and the memory.
interface dmem_ctrl_if;

  rv32i_types::rv32i_word      dmem_address;
  logic                        dmem_read;
  logic                        dmem_write;
  rv32i_types::rv32i_mem_wmask dmem_wmask;
  rv32i_types::rv32i_word      dmem_wdata;
  rv32i_types::rv32i_word      dmem_rdata;
  logic                        dmem_resp;

  modport ctrl (
    output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport mem (
    input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );

endinterface

// File: rtl/dmem_ctrl_load_align.sv
// Selects the addressed byte/halfword from a memory word and sign- or zero-extends it.
module load_align
  import rv32i_types::*;
(
  input  rv32i_word  rdata,
  input  logic [1:0] offset,
  input  logic [2:0] funct3,
  output rv32i_word  data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (offset)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      lb:      data = {{24{w_byte[7]}}, w_byte};
      lbu:     data = {24'h0, w_byte};
      lh:      data = {{16{w_half[15]}}, w_half};
      lhu:     data = {16'h0, w_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: validates, issues and completes one load/store at a time.
module dmem_ctrl
  import rv32i_types::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_read,
  input  logic             req_write,
  input  rv32i_word        req_addr,
  input  logic [2:0]       req_funct3,
  input  rv32i_word        req_wdata,
  output logic             stall,
  output rv32i_word        load_data,
  output logic             load_valid,
  output logic             misaligned,
  dmem_ctrl_if.ctrl        mem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         r_state;
  rv32i_word      r_dmem_address;
  logic           r_dmem_read;
  logic           r_dmem_write;
  rv32i_mem_wmask r_dmem_wmask;
  rv32i_word      r_dmem_wdata;
  rv32i_word      r_load_data;
  logic           r_load_valid;
  logic [2:0]     r_funct3;
  logic [1:0]     r_offset;

  logic      w_mem_op;
  logic      w_f3_ok;
  logic      w_align_ok;
  logic      w_legal;
  logic      w_idle;
  rv32i_word w_aligned;

  always_comb begin
    w_mem_op = req_read | req_write;
    // Unsigned variants exist only for loads; a read+write request counts as a store.
    case (req_funct3)
      lb, lh, lw: w_f3_ok = 1'b1;
      lbu, lhu:   w_f3_ok = ~req_write;
      default:    w_f3_ok = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b00:   w_align_ok = 1'b1;
      2'b01:   w_align_ok = ~req_addr[0];
      2'b10:   w_align_ok = (req_addr[1:0] == 2'b00);
      default: w_align_ok = 1'b0;
    endcase
    w_idle  = (r_state == IDLE);
    w_legal = req_valid & w_mem_op & w_f3_ok & w_align_ok;
  end

  load_align u_load_align (
    .rdata  (mem.dmem_rdata),
    .offset (r_offset),
    .funct3 (r_funct3),
    .data   (w_aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_dmem_address <= '0;
      r_dmem_read    <= 1'b0;
      r_dmem_write   <= 1'b0;
      r_dmem_wmask   <= '0;
      r_dmem_wdata   <= '0;
      r_load_data    <= '0;
      r_load_valid   <= 1'b0;
      r_funct3       <= '0;
      r_offset       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_load_valid <= 1'b0;
          if (w_legal) begin
            r_dmem_address <= {req_addr[31:2], 2'b00};
            r_dmem_wmask   <= gen_wmask(req_funct3, req_addr[1:0]);
            r_dmem_wdata   <= req_wdata << {req_addr[1:0], 3'b000};
            r_dmem_read    <= ~req_write;
            r_dmem_write   <= req_write;
            r_funct3       <= req_funct3;
            r_offset       <= req_addr[1:0];
            r_state        <= BUSY;
          end
        end
        BUSY: begin
          if (mem.dmem_resp) begin
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            if (r_dmem_read) begin
              r_load_data  <= w_aligned;
              r_load_valid <= 1'b1;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_load_valid <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A reset landing mid-transaction must not keep the pipeline held.
  assign stall      = (w_idle & w_legal) | ((r_state == BUSY) & ~rst);
  assign misaligned = w_idle & req_valid & w_mem_op & ~w_legal;
  assign load_data  = r_load_data;
  assign load_valid = r_load_valid;

  assign mem.dmem_address = r_dmem_address;
  assign mem.dmem_read    = r_dmem_read;
  assign mem.dmem_write   = r_dmem_write;
  assign mem.dmem_wmask   = r_dmem_wmask;
  assign mem.dmem_wdata   = r_dmem_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a load-data scoreboard and a bench-driven memory responder.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;

  dmem_ctrl_if mem_if ();

  dmem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_read   (req_read),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misaligned (misaligned),
    .mem        (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;
  logic [31:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_read  = 1'b0;
    req_write = 1'b0;
  endtask

  // One legal access: request in IDLE, nbusy BUSY cycles with resp in the last, then DONE.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [2:0] f3, input logic [31:0] wdata, input logic [31:0] rdata,
                     input int nbusy, input logic is_load, input logic [31:0] exp_addr,
                     input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                     input logic [31:0] exp_load);
    int n_stall;
    req_valid  = 1'b1;
    req_read   = rd;
    req_write  = wr;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wdata;
    if (is_load) sb_q.push_back(exp_load);
    @(negedge clk);
    check("req_stall", {31'h0, stall}, 32'h1);
    check("req_misaligned", {31'h0, misaligned}, 32'h0);
    n_stall = stall ? 1 : 0;
    for (int i = 0; i < nbusy; i++) begin
      next_cycle();
      if (i == nbusy - 1) begin
        mem_if.dmem_resp  = 1'b1;
        mem_if.dmem_rdata = rdata;
      end
      @(negedge clk);
      check("busy_addr", mem_if.dmem_address, exp_addr);
      check("busy_mask", {28'h0, mem_if.dmem_wmask}, {28'h0, exp_mask});
      check("busy_read", {31'h0, mem_if.dmem_read}, {31'h0, is_load});
      check("busy_write", {31'h0, mem_if.dmem_write}, {31'h0, ~is_load});
      if (!is_load) check("busy_wdata", mem_if.dmem_wdata, exp_wdata);
      if (stall) n_stall++;
    end
    next_cycle();
    mem_if.dmem_resp  = 1'b0;
    mem_if.dmem_rdata = 32'h0;
    idle_req();
    @(negedge clk);
    check("done_stall", {31'h0, stall}, 32'h0);
    check("done_read", {31'h0, mem_if.dmem_read}, 32'h0);
    check("done_write", {31'h0, mem_if.dmem_write}, 32'h0);
    check("done_load_valid", {31'h0, load_valid}, {31'h0, is_load});
    if (is_load) begin
      if (sb_q.size() == 0) check("sb_empty", 32'h1, 32'h0);
      else check("load_data", load_data, sb_q.pop_front());
    end
    check("stall_cycles", n_stall, nbusy + 1);
    next_cycle();
    @(negedge clk);
    check("idle_load_valid", {31'h0, load_valid}, 32'h0);
  endtask

  task automatic bad_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [2:0] f3);
    req_valid  = 1'b1;
    req_read   = rd;
    req_write  = wr;
    req_addr   = addr;
    req_funct3 = f3;
    @(negedge clk);
    check("bad_misaligned", {31'h0, misaligned}, 32'h1);
    check("bad_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    idle_req();
    @(negedge clk);
    check("bad_no_read", {31'h0, mem_if.dmem_read}, 32'h0);
    check("bad_no_write", {31'h0, mem_if.dmem_write}, 32'h0);
    check("bad_misaligned_clr", {31'h0, misaligned}, 32'h0);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    idle_req();
    req_addr          = 32'h0;
    req_funct3        = 3'b000;
    req_wdata         = 32'h0;
    mem_if.dmem_resp  = 1'b0;
    mem_if.dmem_rdata = 32'h0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_read", {31'h0, mem_if.dmem_read}, 32'h0);
    check("rst_write", {31'h0, mem_if.dmem_write}, 32'h0);
    check("rst_addr", mem_if.dmem_address, 32'h0);
    check("rst_mask", {28'h0, mem_if.dmem_wmask}, 32'h0);
    check("rst_wdata", mem_if.dmem_wdata, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_load_valid", {31'h0, load_valid}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_misaligned", {31'h0, misaligned}, 32'h0);
    next_cycle();

    // LW, resp after two BUSY cycles
    txn(1'b1, 1'b0, 32'h0000_1000, 3'b010, 32'h0, 32'hDEAD_BEEF, 2, 1'b1,
        32'h0000_1000, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    // LB / LBU of the top byte
    txn(1'b1, 1'b0, 32'h0000_1003, 3'b000, 32'h0, 32'h80FF_0000, 1, 1'b1,
        32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    txn(1'b1, 1'b0, 32'h0000_1003, 3'b100, 32'h0, 32'h80FF_0000, 1, 1'b1,
        32'h0000_1000, 4'b1000, 32'h0, 32'h0000_0080);
    // LH upper half negative, LHU lower half
    txn(1'b1, 1'b0, 32'h0000_1002, 3'b001, 32'h0, 32'h8001_1234, 1, 1'b1,
        32'h0000_1000, 4'b1100, 32'h0, 32'hFFFF_8001);
    txn(1'b1, 1'b0, 32'h0000_1000, 3'b101, 32'h0, 32'h1234_F00D, 3, 1'b1,
        32'h0000_1000, 4'b0011, 32'h0, 32'h0000_F00D);
    // SH to the upper half
    txn(1'b0, 1'b1, 32'h0000_2002, 3'b001, 32'h0000_ABCD, 32'h0, 2, 1'b0,
        32'h0000_2000, 4'b1100, 32'hABCD_0000, 32'h0);
    check("hold_load_data", load_data, 32'h0000_F00D);
    // Read and write together behave as SB
    txn(1'b1, 1'b1, 32'h0000_0000, 3'b000, 32'h0000_0012, 32'h0, 1, 1'b0,
        32'h0000_0000, 4'b0001, 32'h0000_0012, 32'h0);
    // SB at byte 2 shifts data to lane 2
    txn(1'b0, 1'b1, 32'h0000_0042, 3'b000, 32'h0000_0077, 32'h0, 1, 1'b0,
        32'h0000_0040, 4'b0100, 32'h0077_0000, 32'h0);

    // Illegal accesses
    bad_req(1'b1, 1'b0, 32'h0000_1001, 3'b010);
    bad_req(1'b0, 1'b1, 32'h0000_1003, 3'b001);
    bad_req(1'b0, 1'b1, 32'h0000_1000, 3'b100);
    bad_req(1'b1, 1'b0, 32'h0000_1000, 3'b011);

    // Valid with no memory op, plus stray resp in IDLE: nothing happens
    req_valid        = 1'b1;
    mem_if.dmem_resp = 1'b1;
    @(negedge clk);
    check("nop_stall", {31'h0, stall}, 32'h0);
    check("nop_misaligned", {31'h0, misaligned}, 32'h0);
    next_cycle();
    idle_req();
    mem_if.dmem_resp = 1'b0;
    @(negedge clk);
    check("stray_resp_read", {31'h0, mem_if.dmem_read}, 32'h0);
    check("stray_resp_valid", {31'h0, load_valid}, 32'h0);
    check("stray_resp_stall", {31'h0, stall}, 32'h0);
    next_cycle();

    // Reset while BUSY abandons the load; late resp ignored
    req_valid  = 1'b1;
    req_read   = 1'b1;
    req_addr   = 32'h0000_3000;
    req_funct3 = 3'b010;
    @(negedge clk);
    check("rb_req_stall", {31'h0, stall}, 32'h1);
    next_cycle();
    @(negedge clk);
    check("rb_busy_read", {31'h0, mem_if.dmem_read}, 32'h1);
    rst = 1'b1;
    #1;
    check("rb_rst_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    rst = 1'b0;
    idle_req();
    @(negedge clk);
    check("rb_read", {31'h0, mem_if.dmem_read}, 32'h0);
    check("rb_write", {31'h0, mem_if.dmem_write}, 32'h0);
    check("rb_addr", mem_if.dmem_address, 32'h0);
    check("rb_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    mem_if.dmem_resp  = 1'b1;
    mem_if.dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("rb_late_valid", {31'h0, load_valid}, 32'h0);
    check("rb_late_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    mem_if.dmem_resp = 1'b0;
    @(negedge clk);
    check("rb_after_valid", {31'h0, load_valid}, 32'h0);
    check("rb_after_read", {31'h0, mem_if.dmem_read}, 32'h0);
    check("rb_load_data", load_data, 32'h0);

    // Controller still works after the abandoned transaction
    next_cycle();
    txn(1'b1, 1'b0, 32'h0000_3004, 3'b010, 32'h0, 32'h0BAD_F00D, 1, 1'b1,
        32'h0000_3004, 4'b1111, 32'h0, 32'h0BAD_F00D);
    check("sb_drained", sb_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameters: none; all widths SHALL come from rv32i_types.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
REQ-003 Pipeline-side ports SHALL be:
- req_valid  in  1  MEM stage holds a valid instruction
- req_read  in  1  load
- req_write  in  1  store
- req_addr  in  32  byte address from ALU
- req_funct3  in  3  access width and signedness
- req_wdata  in  32  unshifted store data
- stall  out  1  hold the pipeline
- load_data  out  32  aligned, extended load result
- load_valid  out  1  load_data valid this cycle
- misaligned  out  1  access rejected this cycle
REQ-004 Memory-side ports SHALL be:
- dmem_address  out  32  word-aligned address
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_wmask  out  4  byte enables
- dmem_wdata  out  32  byte-lane-shifted store data
- dmem_rdata  in  32  read data
- dmem_resp  in  1  request complete

Function
REQ-005 FSM states SHALL be IDLE, BUSY and DONE.
REQ-006 Legal access SHALL mean: req_valid and (req_read or req_write); funct3 in {000,001,010,100,101}; halfword has addr[0]=0; word has addr[1:0]=00; loads only for 100/101.
REQ-007 When req_read and req_write are both high, the access SHALL be treated as a store.
REQ-008 In IDLE with a legal access:
- stall SHALL be high combinationally in the same cycle.
- The FSM SHALL enter BUSY next edge.
- The edge SHALL register dmem_address={addr[31:2],2'b00}, the byte mask, dmem_wdata=wdata<<(8*addr[1:0]), and dmem_read/dmem_write.
REQ-009 Byte mask rules: byte 0001<<addr[1:0]; half 0011 or 1100 by addr[1]; word 1111.
REQ-010 In IDLE with req_valid, a memory op and an illegal access:
- misaligned SHALL pulse combinationally.
- stall SHALL be low.
- No memory request SHALL be issued.
REQ-011 In BUSY, the request outputs SHALL stay stable and stall SHALL be high until dmem_resp.
REQ-012 On dmem_resp in BUSY:
- dmem_read/dmem_write SHALL clear next edge.
- The FSM SHALL enter DONE.
- For loads, load_data SHALL be registered from dmem_rdata.
REQ-013 Load extraction: LB/LBU take byte addr[1:0]; LH/LHU take half addr[1]; LW takes the full word. LB/LH sign-extend; LBU/LHU zero-extend.
REQ-014 DONE SHALL last exactly one cycle: stall low, load_valid high for loads, then IDLE.
REQ-015 Minimum latency SHALL be 3 cycles, request to stall-release, with dmem_resp in the first BUSY cycle.
REQ-016 dmem_resp outside BUSY SHALL be ignored.
REQ-017 load_data SHALL hold its value until the next completed load.

Reset
REQ-018 On rst the block SHALL:
- enter IDLE;
- clear dmem_read, dmem_write, dmem_wmask, dmem_address, dmem_wdata and load_data to 0;
- hold load_valid, misaligned and stall at 0 unless REQ-008/010 apply combinationally.
REQ-019 rst during BUSY SHALL abandon the transaction; the next-cycle memory request SHALL be 0 and a subsequent late dmem_resp SHALL be ignored.

Structure
REQ-020 rv32i_types SHALL hold rv32i_word, rv32i_mem_wmask, and load/store funct3 enums (lb, lh, lw, lbu, lhu / sb, sh, sw).
REQ-021 The FSM state enum SHALL be local to dmem_ctrl.
REQ-022 Byte extraction and extension SHALL live in one combinational sub-module, load_align (inputs rdata, offset, funct3; output rv32i_word).

Verification
REQ-023 LW at 0x1000, resp after 2 BUSY cycles with rdata 0xDEADBEEF -> dmem_read with mask 1111; stall high 3 cycles; DONE load_data=0xDEADBEEF, load_valid=1.
REQ-024 LB at 0x1003 with rdata 0x80FF0000 -> mask 1000, load_data=0xFFFFFF80; LBU at 0x1003 -> 0x00000080.
REQ-025 SH at 0x2002 with wdata 0x0000ABCD -> dmem_address=0x2000, dmem_wmask=1100, dmem_wdata=0xABCD0000, dmem_write=1 until resp.
REQ-026 LW at 0x1001, then SH at 0x1003 -> misaligned=1, stall=0, no dmem_read/dmem_write for each.
REQ-027 rst asserted in BUSY, then dmem_resp 2 cycles later -> IDLE, requests 0, load_valid stays 0.
REQ-028 req_read and req_write both high, SB at 0x0 with wdata 0x12 -> dmem_write=1, dmem_read=0, mask 0001, dmem_wdata=0x00000012.
